// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch stage: widths, bubble word and
// the opcode field used to recognise the halt instruction.
package if_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 32;
  localparam int IMEM_DEPTH  = 256;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [5:0]             HALT_OPCODE = 6'b111111;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

endpackage

// File: rtl/instruction_memory.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
module instruction_memory #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; program contents must survive a pipeline reset.
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, next-PC selection, IF/ID pipeline register and halt flag.
// Halt-opcode detection is enabled by defining IF_HALT_DETECT_EN.
module instruction_fetch
  import if_pkg::*;
#(
  parameter int                     PC_WIDTH    = if_pkg::PC_WIDTH,
  parameter int                     INSTR_WIDTH = if_pkg::INSTR_WIDTH,
  parameter int                     IMEM_DEPTH  = if_pkg::IMEM_DEPTH,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = if_pkg::NOP_INSTR,
  parameter logic [5:0]             HALT_OPCODE = if_pkg::HALT_OPCODE,
  localparam int                    AW          = $clog2(IMEM_DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_stall,
  input  logic                   i_halt,
  input  logic                   i_jump,
  input  logic [PC_WIDTH-1:0]    i_jump_address,
  input  logic                   i_load_en,
  input  logic [AW-1:0]          i_load_addr,
  input  logic [INSTR_WIDTH-1:0] i_load_data,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic                   o_valid,
  output logic                   o_halted
);

`ifdef IF_HALT_DETECT_EN
  localparam logic HALT_DETECT = 1'b1;
`else
  localparam logic HALT_DETECT = 1'b0;
`endif

  logic [PC_WIDTH-1:0]    pc_q, pc_d, pc_plus4;
  logic [PC_WIDTH-1:0]    if_pc_q, if_pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d, fetch_word;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;
  logic                   halt_hit;

  // A reset on the same edge as a load must not corrupt the program.
  instruction_memory #(.DEPTH(IMEM_DEPTH), .WIDTH(INSTR_WIDTH)) u_imem (
    .i_clk   (i_clk),
    .i_we    (i_load_en & ~i_reset),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_data),
    .i_raddr (pc_q[AW+1:2]),
    .o_rdata (fetch_word)
  );

  assign pc_plus4 = pc_q + PC_WIDTH'(4);
  assign halt_hit = HALT_DETECT && (fetch_word[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);

  // NOTE: every next-state signal gets its hold value first so no path infers a latch.
  always_comb begin
    pc_d     = pc_q;
    if_pc_d  = if_pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (i_load_en) begin
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      halted_d = 1'b0;
    end else if (i_halt) begin
      // debug freeze: everything holds
    end else if (halted_q) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (i_stall) begin
      // stall wins over jump; ID re-issues the jump once the stall drops
    end else if (i_jump) begin
      pc_d    = i_jump_address & ~PC_WIDTH'(3);
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      instr_d = fetch_word;
      if_pc_d = pc_plus4;
      valid_d = 1'b1;
      // the halt word goes downstream once while pc parks on it
      if (halt_hit) halted_d = 1'b1;
      else          pc_d     = pc_plus4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q     <= '0;
      if_pc_q  <= '0;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      if_pc_q  <= if_pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_pc          = if_pc_q;
  assign o_valid       = valid_q;
  assign o_halted      = halted_q;

endmodule
